// File: rtl/iod_dly_responder.sv
// IOD delay-line responder for RX bit-align training: tap counter,
// settle/evaluate FSM and sticky EARLY/LATE/OOR flags against an eye window.
//
// Ports:
//   SCLK               fabric clock, rising edge
//   RESET              synchronous, active-high reset
//   BIT_ALGN_CLR_FLGS  clear EARLY/LATE/OOR (a simultaneous set wins)
//   BIT_ALGN_LOAD      reload tap to TAP_LOAD_VAL, clear OOR
//   BIT_ALGN_DIR       step direction with MOVE (1 = up, 0 = down)
//   BIT_ALGN_MOVE      one tap step per asserted cycle, saturating
//   EYE_LO / EYE_HI    first / last tap inside the valid eye (unsigned)
//   IOD_EARLY          sticky: tap below EYE_LO at evaluation
//   IOD_LATE           sticky: tap above EYE_HI at evaluation
//   IOD_OOR            sticky: move attempted past the tap range
//   TAPDLY             current tap position
//   SETTLED            high while idle and flags reflect the current tap
//
// Optional feature macro: IOD_RSP_JITTER_EN
//   defined   -> 16-bit LFSR randomly flags taps at the two innermost
//                positions of each eye edge, modelling edge jitter
//   undefined -> deterministic window compare only

module iod_dly_responder #(
  parameter int TAP_CNT_WIDTH = 8,
  parameter int TAP_LOAD_VAL  = 0,
  parameter int SETTLE_CYC    = 4
) (
  input  logic                     SCLK,
  input  logic                     RESET,
  input  logic                     BIT_ALGN_CLR_FLGS,
  input  logic                     BIT_ALGN_LOAD,
  input  logic                     BIT_ALGN_DIR,
  input  logic                     BIT_ALGN_MOVE,
  input  logic [TAP_CNT_WIDTH-1:0] EYE_LO,
  input  logic [TAP_CNT_WIDTH-1:0] EYE_HI,
  output logic                     IOD_EARLY,
  output logic                     IOD_LATE,
  output logic                     IOD_OOR,
  output logic [TAP_CNT_WIDTH-1:0] TAPDLY,
  output logic                     SETTLED
);

  localparam int W = TAP_CNT_WIDTH;

  localparam logic [W-1:0] TAP_INIT = W'(TAP_LOAD_VAL);
  localparam logic [W-1:0] TAP_MAX  = '1;
  localparam logic [W-1:0] TAP_ZERO = '0;
  localparam logic [W-1:0] TAP_ONE  = W'(1);
  localparam logic [3:0]   CNT_INIT = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_EVAL
  } state_t;

  // A one-cycle settle time goes straight to evaluation so that the
  // flags always land SETTLE_CYC+1 cycles after the command.
  localparam state_t ST_ARM = (SETTLE_CYC == 1) ? S_EVAL : S_SETTLE;

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_tap;
  logic         r_early;
  logic         r_late;
  logic         r_oor;
  logic         r_settled;

  logic         w_cmd;
  logic         w_up_ok;
  logic         w_dn_ok;
  logic         w_sat;
  logic [W-1:0] w_tap_nxt;
  logic         w_eval;
  logic         w_lo_hit;
  logic         w_hi_hit;
  logic         w_set_early;
  logic         w_set_late;

  assign w_cmd   = BIT_ALGN_LOAD | BIT_ALGN_MOVE;
  assign w_up_ok = (r_tap != TAP_MAX);
  assign w_dn_ok = (r_tap != TAP_ZERO);

  // LOAD overrides MOVE, so a saturating MOVE under LOAD is not an OOR.
  assign w_sat = BIT_ALGN_MOVE & ~BIT_ALGN_LOAD &
                 (BIT_ALGN_DIR ? ~w_up_ok : ~w_dn_ok);

  always_comb begin
    w_tap_nxt = r_tap;
    if (BIT_ALGN_LOAD) begin
      w_tap_nxt = TAP_INIT;
    end else if (BIT_ALGN_MOVE) begin
      if (BIT_ALGN_DIR && w_up_ok) begin
        w_tap_nxt = r_tap + TAP_ONE;
      end else if (!BIT_ALGN_DIR && w_dn_ok) begin
        w_tap_nxt = r_tap - TAP_ONE;
      end
    end
  end

  assign w_eval   = (r_state == S_EVAL);
  assign w_lo_hit = (r_tap < EYE_LO);
  assign w_hi_hit = (r_tap > EYE_HI);

`ifdef IOD_RSP_JITTER_EN
  localparam logic [W:0] WIDE_ONE = (W+1)'(1);

  logic [15:0] r_lfsr;
  logic [W:0]  w_tap_x;
  logic [W:0]  w_lo_x;
  logic [W:0]  w_hi_x;
  logic        w_near_lo;
  logic        w_near_hi;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge SCLK) begin
    if (RESET) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0],
                 r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  // Widened by one bit so EYE_LO+1 / tap+1 cannot wrap at the top.
  assign w_tap_x   = {1'b0, r_tap};
  assign w_lo_x    = {1'b0, EYE_LO};
  assign w_hi_x    = {1'b0, EYE_HI};
  assign w_near_lo = (w_tap_x >= w_lo_x) &&
                     (w_tap_x <= w_lo_x + WIDE_ONE);
  assign w_near_hi = (w_tap_x <= w_hi_x) &&
                     (w_tap_x + WIDE_ONE >= w_hi_x);

  assign w_set_early = w_eval &
                       (w_lo_hit | (w_near_lo & r_lfsr[0]));
  assign w_set_late  = w_eval &
                       (w_hi_hit | (w_near_hi & r_lfsr[0]));
`else
  assign w_set_early = w_eval & w_lo_hit;
  assign w_set_late  = w_eval & w_hi_hit;
`endif

  always_ff @(posedge SCLK) begin
    if (RESET) begin
      r_state   <= ST_ARM;
      r_cnt     <= CNT_INIT;
      r_tap     <= TAP_INIT;
      r_early   <= 1'b0;
      r_late    <= 1'b0;
      r_oor     <= 1'b0;
      r_settled <= 1'b0;
    end else begin
      r_tap <= w_tap_nxt;

      // Sticky flags: clear first, then any set in this cycle wins.
      r_early <= (r_early & ~BIT_ALGN_CLR_FLGS) | w_set_early;
      r_late  <= (r_late & ~BIT_ALGN_CLR_FLGS) | w_set_late;
      if (BIT_ALGN_LOAD) begin
        r_oor <= 1'b0;
      end else begin
        r_oor <= (r_oor & ~BIT_ALGN_CLR_FLGS) | w_sat;
      end

      // Raised only after a full idle cycle, so it never overlaps
      // the cycle in which flags are still being written.
      r_settled <= (r_state == S_IDLE) & ~w_cmd;

      if (w_cmd) begin
        r_state <= ST_ARM;
        r_cnt   <= CNT_INIT;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_SETTLE: begin
            if (r_cnt <= 4'd2) begin
              r_state <= S_EVAL;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_EVAL: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign IOD_EARLY = r_early;
  assign IOD_LATE  = r_late;
  assign IOD_OOR   = r_oor;
  assign TAPDLY    = r_tap;
  assign SETTLED   = r_settled;

endmodule

// File: tb/tb_iod_dly_responder.sv
// Directed bench for iod_dly_responder: expected values are queued with
// a due cycle when stimulus is driven and checked when that cycle comes.
module tb_iod_dly_responder;

  localparam int W = 8;
  localparam int S = 4;

  localparam int TAP = 0;
  localparam int EAR = 1;
  localparam int LAT = 2;
  localparam int OOR = 3;
  localparam int SET = 4;

  logic         SCLK = 1'b0;
  logic         RESET;
  logic         clr;
  logic         ld;
  logic         dir;
  logic         mv;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         early;
  logic         late;
  logic         oor;
  logic [W-1:0] tap;
  logic         settled;

  always #5 SCLK = ~SCLK;

  iod_dly_responder #(
    .TAP_CNT_WIDTH(W),
    .TAP_LOAD_VAL (0),
    .SETTLE_CYC   (S)
  ) dut (
    .SCLK             (SCLK),
    .RESET            (RESET),
    .BIT_ALGN_CLR_FLGS(clr),
    .BIT_ALGN_LOAD    (ld),
    .BIT_ALGN_DIR     (dir),
    .BIT_ALGN_MOVE    (mv),
    .EYE_LO           (lo),
    .EYE_HI           (hi),
    .IOD_EARLY        (early),
    .IOD_LATE         (late),
    .IOD_OOR          (oor),
    .TAPDLY           (tap),
    .SETTLED          (settled)
  );

  typedef struct {
    int    due;
    int    sel;
    int    exp;
    string tag;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] obs(int sel);
    case (sel)
      TAP:     obs = 32'(tap);
      EAR:     obs = 32'(early);
      LAT:     obs = 32'(late);
      OOR:     obs = 32'(oor);
      SET:     obs = 32'(settled);
      default: obs = 'x;
    endcase
  endfunction

  task automatic push(int dly, int sel, int exp, string tag);
    chk_t c;
    c.due = cyc + dly;
    c.sel = sel;
    c.exp = exp;
    c.tag = tag;
    sb.push_back(c);
  endtask

  task automatic tick();
    int i;
    logic [31:0] o;
    @(posedge SCLK);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        o = obs(sb[i].sel);
        checks++;
        assert (o === 32'(sb[i].exp)) else begin
          failures++;
          $error("FAIL %s cyc=%0d got=%0d exp=%0d",
                 sb[i].tag, cyc, o, sb[i].exp);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  task automatic cmd(logic m, logic d, logic l, logic c);
    mv  = m;
    dir = d;
    ld  = l;
    clr = c;
    tick();
    mv  = 1'b0;
    ld  = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    clr   = 1'b0;
    ld    = 1'b0;
    dir   = 1'b0;
    mv    = 1'b0;
    lo    = 8'd40;
    hi    = 8'd90;

    // Reset: tap 0 below the eye -> EARLY after the first settle.
    tick();
    push(1, TAP, 0, "rst_tap");
    push(1, EAR, 0, "rst_early0");
    push(1, LAT, 0, "rst_late0");
    push(1, OOR, 0, "rst_oor0");
    push(1, SET, 0, "rst_settled0");
    push(S, EAR, 0, "rst_early_pre");
    push(S + 1, EAR, 1, "rst_early");
    push(S + 1, LAT, 0, "rst_late");
    push(S + 1, SET, 0, "rst_settle_lo");
    push(S + 2, SET, 1, "rst_settled");
    tick();
    RESET = 1'b0;
    idle(S + 2);

    // Walk up to tap 50, clearing with every move.
    for (int k = 1; k <= 50; k++) begin
      push(1, TAP, k, "walk_tap");
      push(1, EAR, 0, "walk_clr");
      push(1, OOR, 0, "walk_oor");
      push(S + 1, EAR, int'(k < 40), "walk_early");
      push(S + 1, LAT, 0, "walk_late");
      push(S + 1, SET, 0, "walk_eval_busy");
      push(S + 2, SET, 1, "walk_settled");
      cmd(1'b1, 1'b1, 1'b0, 1'b1);
      idle(7);
    end

    // Back-to-back moves 51..254: no evaluation until the burst ends.
    for (int k = 51; k <= 254; k++) begin
      push(1, TAP, k, "burst_tap");
      push(1, SET, 0, "burst_settled");
      push(1, LAT, 0, "burst_late_hold");
      cmd(1'b1, 1'b1, 1'b0, 1'(k == 51));
    end
    push(S - 1, LAT, 0, "burst_no_eval");
    push(S - 1, SET, 0, "burst_settle_lo");
    push(S, LAT, 1, "burst_late");
    push(S, SET, 0, "burst_eval_busy");
    push(S + 1, SET, 1, "burst_settled");
    idle(S + 1);

    // Saturation at the top.
    push(1, TAP, 255, "sat1_tap");
    push(1, OOR, 0, "sat1_oor");
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    idle(7);
    push(1, TAP, 255, "sat2_tap");
    push(1, OOR, 1, "sat2_oor");
    push(S + 1, LAT, 1, "sat2_late");
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    idle(7);
    push(1, TAP, 255, "sat3_tap");
    push(1, OOR, 1, "sat3_oor");
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    idle(7);

    // LOAD returns to tap 0 and clears OOR; LATE stays sticky.
    push(1, TAP, 0, "load_tap");
    push(1, OOR, 0, "load_oor");
    push(S + 1, EAR, 1, "load_early");
    push(S + 1, LAT, 1, "load_late_sticky");
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    idle(7);

    // Saturation at the bottom.
    push(1, TAP, 0, "dnsat_tap");
    push(1, OOR, 1, "dnsat_oor");
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);

    // LOAD beats MOVE and clears OOR.
    push(1, TAP, 0, "ldprio_tap");
    push(1, OOR, 0, "ldprio_oor");
    cmd(1'b1, 1'b1, 1'b1, 1'b0);
    idle(7);

    // CLR with a saturating move: OOR set wins, LATE cleared.
    push(1, OOR, 1, "clr_vs_sat");
    push(1, LAT, 0, "clr_late");
    push(1, EAR, 0, "clr_early");
    push(S + 1, EAR, 1, "clr_reeval");
    cmd(1'b1, 1'b0, 1'b0, 1'b1);
    idle(7);

    // Plain up then down.
    push(1, TAP, 1, "inc_tap");
    cmd(1'b1, 1'b1, 1'b0, 1'b0);
    idle(7);
    push(1, TAP, 0, "dec_tap");
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);

    // Burst to 100, CLR lands exactly on the EVAL cycle.
    for (int k = 1; k <= 100; k++) begin
      push(1, TAP, k, "to100_tap");
      cmd(1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle(S - 1);
    push(1, LAT, 1, "clr_vs_eval_late");
    push(1, EAR, 0, "clr_vs_eval_early");
    push(1, OOR, 0, "clr_vs_eval_oor");
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);

    // RESET in the middle of settling at tap 120.
    for (int k = 101; k <= 120; k++) begin
      push(1, TAP, k, "to120_tap");
      cmd(1'b1, 1'b1, 1'b0, 1'b0);
    end
    idle(1);
    RESET = 1'b1;
    push(1, TAP, 0, "rstmid_tap");
    push(1, EAR, 0, "rstmid_early");
    push(1, LAT, 0, "rstmid_late");
    push(1, OOR, 0, "rstmid_oor");
    push(1, SET, 0, "rstmid_settled");
    push(3, LAT, 0, "rstmid_abort");
    push(S + 1, LAT, 0, "rstmid_late_after");
    push(S + 1, EAR, 1, "rstmid_early_after");
    push(S + 2, SET, 1, "rstmid_settled_after");
    tick();
    RESET = 1'b0;
    idle(S + 2);

    // Degenerate window: LO=60 > HI=30.
    lo = 8'd60;
    hi = 8'd30;
    for (int k = 1; k <= 45; k++) begin
      cmd(1'b1, 1'b1, 1'b0, 1'(k == 1));
    end
    push(S - 1, EAR, 0, "degen_pre_early");
    push(S - 1, LAT, 0, "degen_pre_late");
    push(S, EAR, 1, "degen_both_early");
    push(S, LAT, 1, "degen_both_late");
    idle(S + 2);
    for (int k = 1; k <= 25; k++) begin
      if (k == 25) begin
        push(1, TAP, 20, "degen_tap20");
      end
      cmd(1'b1, 1'b0, 1'b0, 1'(k == 1));
    end
    push(S, EAR, 1, "degen_lo_early");
    push(S, LAT, 0, "degen_lo_late");
    idle(S + 2);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_drain got=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
